// File: rtl/exc_pkg.sv
// exc_pkg: shared ExcCode values, widths and flush-FSM state encodings for the exception tracker.
package exc_pkg;
    localparam int CODE_W = 5;
    localparam logic [CODE_W-1:0] EXC_INT     = 5'd0;
    localparam logic [CODE_W-1:0] EXC_ADEL    = 5'd4;
    localparam logic [CODE_W-1:0] EXC_ADES    = 5'd5;
    localparam logic [CODE_W-1:0] EXC_SYSCALL = 5'd8;
    localparam logic [CODE_W-1:0] EXC_RI      = 5'd10;
    localparam logic [CODE_W-1:0] EXC_OV      = 5'd12;
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;
endpackage

// File: rtl/exc_code_pipe_if.sv
// exc_code_pipe_if: fetch, stall, local-source and commit-side signals of exc_code_pipe.
// Defining EXC_COUNT_EN adds the exc_count output.
interface exc_code_pipe_if #(
    parameter int NUM_STAGES    = 3,
    parameter int SRC_PER_STAGE = 4,
    parameter int CODE_W        = exc_pkg::CODE_W,
    parameter int PC_W          = 32
);
    logic                                   f_valid;
    logic [CODE_W-1:0]                      f_code;
    logic [PC_W-1:0]                        f_pc;
    logic                                   f_bd;
    logic [NUM_STAGES-1:0]                  stall;
    logic [NUM_STAGES*SRC_PER_STAGE-1:0]    src_valid;
    logic [NUM_STAGES*SRC_PER_STAGE*CODE_W-1:0] src_code;
    logic                                   int_req;
    logic                                   eret;
    logic [NUM_STAGES*CODE_W-1:0]           stage_code;
    logic                                   exc_req;
    logic [CODE_W-1:0]                      exc_code;
    logic [PC_W-1:0]                        epc;
    logic                                   exl;
`ifdef EXC_COUNT_EN
    logic [15:0]                            exc_count;
`endif
    modport master (
        output f_valid, f_code, f_pc, f_bd, stall, src_valid, src_code, int_req, eret,
        input  stage_code, exc_req, exc_code, epc, exl
`ifdef EXC_COUNT_EN
        , input exc_count
`endif
    );
    modport slave (
        input  f_valid, f_code, f_pc, f_bd, stall, src_valid, src_code, int_req, eret,
        output stage_code, exc_req, exc_code, epc, exl
`ifdef EXC_COUNT_EN
        , output exc_count
`endif
    );
endinterface

// File: rtl/exc_stage_merge.sv
// exc_stage_merge: oldest-wins merge of one stage's carried exception with its local sources.
module exc_stage_merge #(
    parameter int SRC_PER_STAGE = 4,
    parameter int CODE_W        = 5
) (
    input  logic                              valid,
    input  logic                              has_in,
    input  logic [CODE_W-1:0]                 code_in,
    input  logic [SRC_PER_STAGE-1:0]          src_valid,
    input  logic [SRC_PER_STAGE*CODE_W-1:0]   src_code,
    output logic                              has_out,
    output logic [CODE_W-1:0]                 code_out
);
    // Descending scan so the lowest-index asserted source is the last writer.
    always_comb begin
        has_out = valid && has_in;
        code_out = has_out ? code_in : '0;
        for (int i = SRC_PER_STAGE - 1; i >= 0; i--)
            if (valid && !has_in && src_valid[i]) begin
                has_out = 1'b1;
                code_out = src_code[i*CODE_W +: CODE_W];
            end
    end
endmodule

// File: rtl/exc_code_pipe.sv
// exc_code_pipe: per-instruction ExcCode/PC/BD tracker with commit-stage exception request,
// EPC/EXL capture and a one-cycle flush. Defining EXC_COUNT_EN adds a saturating exc_count.
module exc_code_pipe #(
    parameter int NUM_STAGES    = 3,
    parameter int SRC_PER_STAGE = 4,
    parameter int CODE_W        = 5,
    parameter int PC_W          = 32
) (
    input  logic           clk,
    input  logic           reset,
    exc_code_pipe_if.slave bus
);
    import exc_pkg::*;
    localparam int N = NUM_STAGES;
    logic [N-1:0]             valid_q, valid_d, has_q, has_d, bd_q, bd_d;
    logic [N-1:0][CODE_W-1:0] code_q, code_d;
    logic [N-1:0][PC_W-1:0]   pc_q, pc_d;
    logic [N-1:0]             m_has, in_v, in_h, in_bd, keep, clear;
    logic [N-1:0][CODE_W-1:0] m_code, in_c;
    logic [N-1:0][PC_W-1:0]   in_pc;
    logic [0:0]               state_q, state_d;
    logic [PC_W-1:0]          epc_q, epc_d;
    logic                     exl_q, exl_d, commit, take_int, exc_req;
    genvar k;
    generate
        for (k = 0; k < N; k++) begin : g_merge
            exc_stage_merge #(.SRC_PER_STAGE(SRC_PER_STAGE), .CODE_W(CODE_W)) u_merge (
                .valid     (valid_q[k]),
                .has_in    (has_q[k]),
                .code_in   (code_q[k]),
                .src_valid (bus.src_valid[k*SRC_PER_STAGE +: SRC_PER_STAGE]),
                .src_code  (bus.src_code[k*SRC_PER_STAGE*CODE_W +: SRC_PER_STAGE*CODE_W]),
                .has_out   (m_has[k]),
                .code_out  (m_code[k])
            );
        end
    endgenerate
    // Stage k loads the merged view of stage k-1; stage 0 loads fetch.
    always_comb begin
        in_v = {valid_q[N-2:0], bus.f_valid};
        in_h = {m_has[N-2:0], |bus.f_code};
        in_c = {m_code[N-2:0], bus.f_code};
        in_pc = {pc_q[N-2:0], bus.f_pc};
        in_bd = {bd_q[N-2:0], bus.f_bd};
        keep = bus.stall & {N{state_q == ST_RUN}};
        clear = {N{state_q == ST_FLUSH}} | {bus.stall[N-2:0], 1'b0};
        valid_d = (keep & valid_q) | (~keep & ~clear & in_v);
        has_d = (keep & has_q) | (~keep & ~clear & in_h);
        bd_d = (keep & bd_q) | (~keep & ~clear & in_bd);
        for (int i = 0; i < N; i++) begin
            code_d[i] = keep[i] ? code_q[i] : clear[i] ? '0 : in_c[i];
            pc_d[i] = keep[i] ? pc_q[i] : clear[i] ? '0 : in_pc[i];
        end
    end
    always_comb begin
        commit = state_q == ST_RUN && valid_q[N-1];
        take_int = commit && bus.int_req && !exl_q;
        exc_req = take_int || (commit && m_has[N-1]);
        state_d = exc_req ? ST_FLUSH : ST_RUN;
        epc_d = !exc_req ? epc_q : bd_q[N-1] ? pc_q[N-1] - PC_W'(4) : pc_q[N-1];
        exl_d = exc_req || (exl_q && !(commit && bus.eret));
    end
    assign bus.exc_req = exc_req;
    assign bus.exc_code = take_int ? CODE_W'(EXC_INT) : exc_req ? m_code[N-1] : '0;
    assign bus.stage_code = m_code;
    assign bus.epc = epc_q;
    assign bus.exl = exl_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            has_q <= '0;
            bd_q <= '0;
            code_q <= '0;
            pc_q <= '0;
            state_q <= ST_RUN;
            epc_q <= '0;
            exl_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            has_q <= has_d;
            bd_q <= bd_d;
            code_q <= code_d;
            pc_q <= pc_d;
            state_q <= state_d;
            epc_q <= epc_d;
            exl_q <= exl_d;
        end
    end
`ifdef EXC_COUNT_EN
    logic [15:0] cnt_q, cnt_d;
    always_comb cnt_d = cnt_q + 16'(exc_req && cnt_q != 16'hFFFF);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    assign bus.exc_count = cnt_q;
`endif
endmodule

// File: tb/tb_exc_code_pipe.sv
// tb_exc_code_pipe: directed scenarios plus random traffic checked against an instruction-level model.
module tb_exc_code_pipe;
    import exc_pkg::*;
    localparam int N = 3, S = 4, CW = 5;
    typedef struct {bit v; logic [4:0] code; logic [31:0] pc; bit bd;} insn_t;
    logic clk = 0, reset = 1;
    always #5 clk = ~clk;
    exc_code_pipe_if bus();
    exc_code_pipe dut (.clk(clk), .reset(reset), .bus(bus));
    insn_t st[N];
    bit m_flush, m_exl;
    logic [31:0] m_epc;
    int m_cnt;
    int n_chk = 0, n_fail = 0;
    logic [4:0] codes[5] = '{EXC_ADEL, EXC_ADES, EXC_SYSCALL, EXC_RI, EXC_OV};

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic insn_t merged(int k);
        insn_t r = st[k];
        if (!r.v) begin
            r.code = 0;
            return r;
        end
        if (r.code == 0)
            for (int i = 0; i < S; i++)
                if (bus.src_valid[k*S+i]) begin
                    r.code = bus.src_code[(k*S+i)*CW +: CW];
                    break;
                end
        return r;
    endfunction

    function automatic bit intk();
        insn_t c = merged(N-1);
        return !m_flush && c.v && bus.int_req && !m_exl;
    endfunction

    function automatic bit take();
        insn_t c = merged(N-1);
        return !m_flush && c.v && (intk() || c.code != 0);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) st[k] = '{0, 0, 0, 0};
        m_flush = 0; m_exl = 0; m_epc = 0; m_cnt = 0;
    endtask

    task automatic compare();
        insn_t c = merged(N-1);
        chk("exc_req", bus.exc_req, take());
        chk("exc_code", bus.exc_code, !take() ? 0 : intk() ? 0 : c.code);
        for (int k = 0; k < N; k++) chk($sformatf("stage_code%0d", k), bus.stage_code[k*CW +: CW], merged(k).code);
        chk("epc", bus.epc, m_epc);
        chk("exl", bus.exl, m_exl);
`ifdef EXC_COUNT_EN
        chk("exc_count", bus.exc_count, m_cnt);
`endif
    endtask

    task automatic model_edge();
        insn_t m[N], nx[N], c, z;
        bit t = take();
        z = '{0, 0, 0, 0};
        for (int k = 0; k < N; k++) m[k] = merged(k);
        c = m[N-1];
        for (int k = 0; k < N; k++) begin
            if (m_flush) nx[k] = z;
            else if (bus.stall[k]) nx[k] = st[k];
            else if (k > 0 && bus.stall[k-1]) nx[k] = z;
            else if (k == 0) nx[k] = '{bus.f_valid, bus.f_valid ? bus.f_code : 5'd0, bus.f_pc, bus.f_bd};
            else nx[k] = m[k-1];
        end
        if (t) begin
            m_epc = c.bd ? c.pc - 32'd4 : c.pc;
            m_exl = 1;
            if (m_cnt < 16'hFFFF) m_cnt++;
        end else if (!m_flush && c.v && bus.eret) m_exl = 0;
        m_flush = t;
        st = nx;
    endtask

    task automatic settle();
        #1;
        compare();
    endtask

    task automatic adv();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) begin
            settle();
            adv();
        end
    endtask

    task automatic clr();
        bus.f_valid = 0; bus.f_code = 0; bus.f_pc = 0; bus.f_bd = 0;
        bus.stall = 0; bus.src_valid = 0; bus.src_code = 0; bus.eret = 0;
    endtask

    task automatic feed(logic [4:0] code, logic [31:0] pc, bit bd);
        bus.f_valid = 1; bus.f_code = code; bus.f_pc = pc; bus.f_bd = bd;
    endtask

    initial begin
        logic [S*N-1:0] sv;
        logic [S*N*CW-1:0] sc;
        int got, pulses, r;
        logic [31:0] pc;
        clr();
        bus.int_req = 0;
        #1;
        chk("rst_exc_req", bus.exc_req, 0);
        chk("rst_exc_code", bus.exc_code, 0);
        chk("rst_exl", bus.exl, 0);
        chk("rst_epc", bus.epc, 0);
        chk("rst_stage_code", bus.stage_code, 0);
        model_reset();
        @(negedge clk);
        reset = 0;
        // overflow raised in E
        feed(0, 32'h1000, 0); run(1);
        clr(); run(1);
        bus.src_valid[4] = 1; bus.src_code[4*CW +: CW] = EXC_OV;
        settle(); chk("ov_stage1", bus.stage_code[CW +: CW], 12); adv();
        clr(); settle();
        chk("ov_req", bus.exc_req, 1); chk("ov_code", bus.exc_code, 12); adv();
        settle(); chk("ov_flush_req", bus.exc_req, 0); chk("ov_epc", bus.epc, 32'h1000); chk("ov_exl", bus.exl, 1); adv();
        settle(); chk("ov_bubbles", bus.stage_code, 0); adv();
        // older wins
        feed(EXC_ADEL, 32'h2000, 0); run(1);
        clr(); run(1);
        bus.src_valid[4] = 1; bus.src_code[4*CW +: CW] = EXC_OV;
        settle(); chk("old_stage1", bus.stage_code[CW +: CW], 4); adv();
        clr(); settle(); chk("old_code", bus.exc_code, 4); adv();
        run(1);
        // delay slot
        feed(EXC_RI, 32'h3008, 1); run(1);
        clr(); run(2);
        settle(); chk("bd_code", bus.exc_code, 10); adv();
        settle(); chk("bd_epc", bus.epc, 32'h3004); adv();
        // eret clears exl
        feed(0, 32'h4000, 0); run(1);
        clr(); run(2);
        bus.eret = 1; settle(); chk("eret_noreq", bus.exc_req, 0); adv();
        bus.eret = 0; settle(); chk("eret_exl", bus.exl, 0);
        // interrupt vs exl
        bus.int_req = 1; got = 0; pc = 32'h4100;
        for (int i = 0; i < 10 && got == 0; i++) begin
            feed(0, pc, 0); pc += 4;
            settle();
            if (bus.exc_req) begin
                got = 1;
                chk("int_code", bus.exc_code, 0);
            end
            adv();
        end
        chk("int_taken", got, 1);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            feed(0, pc, 0); pc += 4;
            settle(); pulses += int'(bus.exc_req); adv();
        end
        chk("int_masked", pulses, 0);
        chk("int_exl", bus.exl, 1);
        feed(0, pc, 0); pc += 4; bus.eret = 1;
        settle(); chk("int_eret_noreq", bus.exc_req, 0); adv();
        bus.eret = 0; feed(0, pc, 0);
        settle(); chk("int_after_eret_exl", bus.exl, 0); chk("int_after_eret_req", bus.exc_req, 1); adv();
        bus.int_req = 0; clr(); run(2);
        // stall bubble
        feed(0, 32'h5000, 0); run(1);
        feed(EXC_SYSCALL, 32'h5004, 0); run(1);
        feed(0, 32'h5008, 0); run(1);
        clr(); bus.stall = 3'b011; run(1);
        bus.src_valid[11:8] = 4'hF;
        for (int i = 8; i < 12; i++) bus.src_code[i*CW +: CW] = EXC_OV;
        for (int j = 0; j < 2; j++) begin
            settle();
            chk("stall_noreq", bus.exc_req, 0);
            chk("stall_bubble", bus.stage_code[2*CW +: CW], 0);
            chk("stall_hold", bus.stage_code[CW +: CW], 8);
            if (j == 0) adv();
        end
        adv();
        clr(); run(1);
        settle(); chk("stall_release_code", bus.exc_code, 8); adv();
        run(2);
        // reset during flush
        feed(EXC_OV, 32'h6000, 0); run(1);
        clr(); run(2);
        settle(); chk("rf_req", bus.exc_req, 1); adv();
        reset = 1;
        #1;
        chk("rf_exl", bus.exl, 0);
        chk("rf_epc", bus.epc, 0);
        chk("rf_req0", bus.exc_req, 0);
`ifdef EXC_COUNT_EN
        chk("rf_count", bus.exc_count, 0);
`endif
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 0;
        // random traffic
        for (int c = 0; c < 600; c++) begin
            bus.f_valid = $urandom_range(0, 3) != 0;
            bus.f_code = ($urandom_range(0, 5) == 0) ? codes[$urandom_range(0, 4)] : 5'd0;
            bus.f_pc = $urandom & ~32'h3;
            bus.f_bd = $urandom_range(0, 3) == 0;
            r = $urandom_range(0, 7);
            bus.stall = r < 4 ? 3'b000 : r == 4 ? 3'b001 : r == 5 ? 3'b011 : 3'b111;
            for (int i = 0; i < S*N; i++) begin
                sv[i] = $urandom_range(0, 11) == 0;
                sc[i*CW +: CW] = codes[$urandom_range(0, 4)];
            end
            bus.src_valid = sv;
            bus.src_code = sc;
            if ($urandom_range(0, 15) == 0) bus.int_req = ~bus.int_req;
            bus.eret = $urandom_range(0, 5) == 0;
            run(1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
